// File: rtl/bank_timing_checker_if.sv
// Command/grant bus of the bank timing checker.
//   req_valid/req_ready/req_cmd/req_bank : command request handshake
//   bank_cnt_flat  : per-bank residual timing count, 5 bits per bank
//   bank_code_flat : per-bank last-command code, 3 bits per bank
//   ras_cnt_flat   : per-bank residual tRAS count, 6 bits per bank
//   grant_valid/grant_cmd/grant_bank : one-cycle issue pulse
//   cmd_err      : one-cycle pulse for a dropped illegal command
//   stall_cycles : WAIT cycles of the current/last request (saturating)
// master = requester / bank-state source, slave = checker.
interface bank_timing_checker_if #(
  parameter int NUM_BANKS = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_cmd;
  logic [2:0]             req_bank;
  logic [NUM_BANKS*5-1:0] bank_cnt_flat;
  logic [NUM_BANKS*3-1:0] bank_code_flat;
  logic [NUM_BANKS*6-1:0] ras_cnt_flat;
  logic                   grant_valid;
  logic [2:0]             grant_cmd;
  logic [2:0]             grant_bank;
  logic                   cmd_err;
  logic [7:0]             stall_cycles;

  modport master (
    output req_valid, req_cmd, req_bank, bank_cnt_flat, bank_code_flat, ras_cnt_flat,
    input  req_ready, grant_valid, grant_cmd, grant_bank, cmd_err, stall_cycles
  );

  modport slave (
    input  req_valid, req_cmd, req_bank, bank_cnt_flat, bank_code_flat, ras_cnt_flat,
    output req_ready, grant_valid, grant_cmd, grant_bank, cmd_err, stall_cycles
  );
endinterface

// File: rtl/bank_timing_checker.sv
// Bank timing checker: accepts one DRAM command at a time, holds it until the
// per-bank timing counters, tRRD and (optionally) tFAW allow it, then pulses a
// one-cycle grant.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - bank_timing_checker_if.slave (request, bank state, grant, status)
// Optional feature: define TFAW_CHECK_EN to add a four-entry ACT history that
// enforces the rolling four-activate window of CYCLE_TFAW clocks.
module bank_timing_checker #(
  parameter int NUM_BANKS  = 8,
  parameter int CYCLE_TRRD = 4,
  parameter int CYCLE_TFAW = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bank_timing_checker_if.slave  bus
);
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;
  localparam int         TW      = $clog2(CYCLE_TRRD + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT, S_GRANT} state_t;

  state_t                   r_state, w_nxt;
  logic [2:0]               r_cmd, r_bank;
  logic [7:0]               r_stall;
  logic                     r_cmd_err;
  logic [TW-1:0]            r_trrd;

  logic [NUM_BANKS-1:0][4:0] w_cnt;
  logic [NUM_BANKS-1:0][2:0] w_code;
  logic [NUM_BANKS-1:0][5:0] w_ras;
  logic [NUM_BANKS-1:0]      w_busy;
  logic [4:0]                w_tcnt;
  logic [2:0]                w_tcode;
  logic [5:0]                w_tras;
  logic                      w_hot, w_faw_full, w_legal, w_illegal, w_act_go;

  // Unpack the flat bank-state vectors.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_cnt[b]  = bus.bank_cnt_flat[5*b +: 5];
    assign w_code[b] = bus.bank_code_flat[3*b +: 3];
    assign w_ras[b]  = bus.ras_cnt_flat[6*b +: 6];
    assign w_busy[b] = (|w_cnt[b]) | (|w_ras[b]);
  end

  // Legality of the latched command against same-cycle bank state.
  always_comb begin
    w_tcnt  = '0;
    w_tcode = '0;
    w_tras  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_bank == 3'(b)) begin
        w_tcnt  = w_cnt[b];
        w_tcode = w_code[b];
        w_tras  = w_ras[b];
      end
    end
    // A zero count unblocks whatever the code says.
    w_hot     = (w_tcnt != '0);
    w_illegal = (r_cmd > CMD_REF);
    case (r_cmd)
      CMD_NOP: w_legal = 1'b1;
      CMD_ACT: w_legal = !(w_hot && (w_tcode == 3'd2 || w_tcode == 3'd5 || w_tcode == 3'd6))
                         && (r_trrd == '0) && !w_faw_full;
      CMD_RD,
      CMD_WR:  w_legal = !(w_hot && w_tcode == 3'd3);
      CMD_PRE: w_legal = (w_tras == '0) && !(w_hot && (w_tcode == 3'd1 || w_tcode == 3'd4));
      CMD_REF: w_legal = (w_busy == '0);
      default: w_legal = 1'b0;
    endcase
  end

  // ACT counters load on the decision edge so they already read their full
  // value during the grant cycle; this gives grant-to-grant spacing of exactly
  // CYCLE_TRRD (and CYCLE_TFAW for the fifth ACT).
  assign w_act_go = (w_nxt == S_GRANT) && (r_cmd == CMD_ACT);

`ifdef TFAW_CHECK_EN
  localparam int FW = $clog2(CYCLE_TFAW + 1);
  logic [3:0][FW-1:0] r_faw;
  logic [3:0]         w_faw_live;
  logic [1:0]         w_faw_slot;

  // Lowest expired entry takes the new ACT; an ACT is only granted when at
  // least one entry is zero, so a free slot always exists.
  always_comb begin
    w_faw_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_faw_live[i] = (r_faw[i] != '0);
      if (r_faw[i] == '0) w_faw_slot = 2'(i);
    end
  end
  assign w_faw_full = &w_faw_live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_faw <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_act_go && w_faw_slot == 2'(i)) r_faw[i] <= FW'(CYCLE_TFAW - 1);
        else if (r_faw[i] != '0)             r_faw[i] <= r_faw[i] - 1'b1;
      end
    end
  end
`else
  assign w_faw_full = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // FSM: next state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_nxt = S_CHECK;
      S_CHECK: begin
        if (w_illegal)    w_nxt = S_IDLE;
        else if (w_legal) w_nxt = S_GRANT;
        else              w_nxt = S_WAIT;
      end
      S_WAIT:  if (w_legal) w_nxt = S_GRANT;
      S_GRANT: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready    = (r_state == S_IDLE);
    bus.grant_valid  = (r_state == S_GRANT);
    bus.grant_cmd    = (r_state == S_GRANT) ? r_cmd  : 3'd0;
    bus.grant_bank   = (r_state == S_GRANT) ? r_bank : 3'd0;
    bus.cmd_err      = r_cmd_err;
    bus.stall_cycles = r_stall;
  end

  // Datapath: request latch, stall counter, error pulse, tRRD counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_bank    <= '0;
      r_stall   <= '0;
      r_cmd_err <= 1'b0;
      r_trrd    <= '0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_cmd   <= bus.req_cmd;
        r_bank  <= bus.req_bank;
        r_stall <= '0;
      end else if (w_nxt == S_WAIT && r_stall != 8'hFF) begin
        // one count per failed evaluation == one per WAIT cycle spent
        r_stall <= r_stall + 8'd1;
      end
      r_cmd_err <= (r_state == S_CHECK) && w_illegal;
      if (w_act_go)            r_trrd <= TW'(CYCLE_TRRD - 1);
      else if (r_trrd != '0)   r_trrd <= r_trrd - 1'b1;
    end
  end
endmodule

// File: tb/tb_bank_timing_checker.sv
// Self-checking bench for bank_timing_checker: directed scenarios plus
// randomized requests compared against a timestamp-based rule model.
module tb_bank_timing_checker;
  localparam int NB   = 8;
  localparam int TRRD = 4;
  localparam int TFAW = 20;
`ifdef TFAW_CHECK_EN
  localparam int FAW_LIM = 4;
  localparam int EXP_5TH = 20;
`else
  localparam int FAW_LIM = 1000;
  localparam int EXP_5TH = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_timing_checker_if #(.NUM_BANKS(NB)) bus();

  bank_timing_checker #(.NUM_BANKS(NB), .CYCLE_TRRD(TRRD), .CYCLE_TFAW(TFAW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cnt[NB];
  int code[NB];
  int ras[NB];
  bit auto_dec = 1'b1;
  int act_hist[$];   // cycles in which an ACT grant_valid was seen

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_banks();
    for (int b = 0; b < NB; b++) begin
      bus.bank_cnt_flat[5*b +: 5]  = 5'(cnt[b]);
      bus.bank_code_flat[3*b +: 3] = 3'(code[b]);
      bus.ras_cnt_flat[6*b +: 6]   = 6'(ras[b]);
    end
  endtask

  task automatic clear_banks();
    for (int b = 0; b < NB; b++) begin
      cnt[b] = 0; code[b] = 0; ras[b] = 0;
    end
    drive_banks();
  endtask

  task automatic age_banks();
    if (auto_dec) begin
      for (int b = 0; b < NB; b++) begin
        if (cnt[b] > 0) cnt[b]--;
        if (ras[b] > 0) ras[b]--;
      end
    end
    drive_banks();
  endtask

  // Rule model: may the command be granted if decided in cycle t (grant at t+1)?
  function automatic bit model_legal(input int cmd, input int bank, input int t);
    bit hot;
    int recent;
    hot = (cnt[bank] != 0);
    recent = 0;
    case (cmd)
      0: return 1'b1;
      1: begin
        if (hot && (code[bank] == 2 || code[bank] == 5 || code[bank] == 6)) return 1'b0;
        foreach (act_hist[i]) begin
          if (t + 1 - act_hist[i] < TRRD) return 1'b0;
          if (t + 1 - act_hist[i] < TFAW) recent++;
        end
        return (recent < FAW_LIM);
      end
      2, 3: return !(hot && code[bank] == 3);
      4: return (ras[bank] == 0) && !(hot && (code[bank] == 1 || code[bank] == 4));
      5: begin
        for (int b = 0; b < NB; b++) if (cnt[b] != 0 || ras[b] != 0) return 1'b0;
        return 1'b1;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Issue one request in the current cycle and follow it to grant/error.
  // release_at >= 0 clears the target bank's counts after that many WAIT polls.
  task automatic run_req(input int cmd, input int bank, input int release_at, output int gcyc);
    int n;
    int exp_stall;
    gcyc = -1;
    n = cyc;
    bus.req_valid = 1'b1;
    bus.req_cmd   = 3'(cmd);
    bus.req_bank  = 3'(bank);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_at_accept: got %b want 1 (cyc %0d)", bus.req_ready, cyc);
    end
    tick();                      // CHECK cycle: bank state held
    bus.req_valid = 1'b0;
    if (cmd > 5) begin
      tick(); age_banks();
      n_cmp++;
      if (bus.cmd_err !== 1'b1 || bus.grant_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL cmd_err_pulse: err=%b gv=%b want err=1 gv=0", bus.cmd_err, bus.grant_valid);
      end
      tick(); age_banks();
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.cmd_err !== 1'b0 || bus.grant_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL after_err: ready=%b err=%b gv=%b want 1/0/0", bus.req_ready, bus.cmd_err, bus.grant_valid);
      end
      return;
    end
    for (int k = 0; k < 400; k++) begin
      if (k == release_at) begin
        cnt[bank] = 0; ras[bank] = 0; drive_banks();
      end
      n_cmp++;
      if (bus.grant_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL early_grant: gv=%b want 0 (cyc %0d, cmd %0d)", bus.grant_valid, cyc, cmd);
      end
      if (model_legal(cmd, bank, cyc)) begin
        exp_stall = cyc - (n + 1);
        if (exp_stall > 255) exp_stall = 255;
        tick(); age_banks();
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_cmd !== 3'(cmd) ||
            bus.grant_bank !== 3'(bank) || bus.stall_cycles !== 8'(exp_stall)) begin
          n_bad++;
          $display("FAIL grant: gv=%b cmd=%0d bank=%0d stall=%0d want 1/%0d/%0d/%0d (cyc %0d)",
                   bus.grant_valid, bus.grant_cmd, bus.grant_bank, bus.stall_cycles,
                   cmd, bank, exp_stall, cyc);
        end
        if (cmd == 1) act_hist.push_back(cyc);
        gcyc = cyc;
        tick(); age_banks();     // back in IDLE
        return;
      end
      tick(); age_banks();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL grant_timeout: no grant for cmd %0d bank %0d", cmd, bank);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    act_hist.delete();
    tick();
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_bank = '0;
    clear_banks();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.grant_valid !== 1'b0 || bus.grant_cmd !== 3'd0 || bus.grant_bank !== 3'd0 ||
        bus.cmd_err !== 1'b0 || bus.stall_cycles !== 8'd0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: gv=%b cmd=%0d bank=%0d err=%b stall=%0d ready=%b want 0/0/0/0/0/1",
               bus.grant_valid, bus.grant_cmd, bus.grant_bank, bus.cmd_err, bus.stall_cycles, bus.req_ready);
    end
    rst_n = 1'b1;
    act_hist.delete();
    tick();
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: ready=%b gv=%b want 1/0", bus.req_ready, bus.grant_valid);
    end
  endtask

  task automatic test_act_basic();
    int n0, g;
    clear_banks();
    n0 = cyc;
    run_req(1, 2, -1, g);
    n_cmp++;
    if (g - n0 != 2) begin
      n_bad++;
      $display("FAIL act_latency: got %0d want 2", g - n0);
    end
  endtask

  task automatic test_rd_wait();
    int n0, g;
    clear_banks();
    cnt[5] = 3; code[5] = 3; drive_banks();
    n0 = cyc;
    run_req(2, 5, -1, g);
    n_cmp++;
    if (g - n0 != 5 || bus.stall_cycles !== 8'd3) begin
      n_bad++;
      $display("FAIL rd_wait: latency=%0d stall=%0d want 5/3", g - n0, bus.stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    int g1, g2;
    clear_banks();
    repeat (TFAW) tick();
    run_req(1, 0, -1, g1);
    run_req(1, 1, -1, g2);
    n_cmp++;
    if (g2 - g1 != TRRD) begin
      n_bad++;
      $display("FAIL act_b2b: spacing=%0d want %0d", g2 - g1, TRRD);
    end
  endtask

  task automatic test_illegal();
    int g;
    clear_banks();
    run_req(7, 0, -1, g);
    run_req(6, 3, -1, g);
  endtask

  task automatic test_faw();
    int g[5];
    clear_banks();
    reset_dut();
    for (int i = 0; i < 5; i++) run_req(1, i, -1, g[i]);
    n_cmp++;
`ifdef TFAW_CHECK_EN
    if (g[4] - g[0] < EXP_5TH) begin
`else
    if (g[4] - g[0] != EXP_5TH) begin
`endif
      n_bad++;
      $display("FAIL faw_fifth: spacing=%0d want %0d", g[4] - g[0], EXP_5TH);
    end
  endtask

  task automatic test_reset_in_wait();
    auto_dec = 1'b0;
    clear_banks();
    cnt[3] = 10; code[3] = 1; drive_banks();
    bus.req_valid = 1'b1; bus.req_cmd = 3'd4; bus.req_bank = 3'd3;
    tick();
    bus.req_valid = 1'b0;
    tick();                          // WAIT
    n_cmp++;
    if (bus.req_ready !== 1'b0 || bus.grant_valid !== 1'b0 || bus.stall_cycles !== 8'd1) begin
      n_bad++;
      $display("FAIL in_wait: ready=%b gv=%b stall=%0d want 0/0/1", bus.req_ready, bus.grant_valid, bus.stall_cycles);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (bus.grant_valid !== 1'b0 || bus.grant_cmd !== 3'd0 || bus.grant_bank !== 3'd0 ||
        bus.cmd_err !== 1'b0 || bus.stall_cycles !== 8'd0) begin
      n_bad++;
      $display("FAIL wait_reset: gv=%b cmd=%0d bank=%0d err=%b stall=%0d want zeros",
               bus.grant_valid, bus.grant_cmd, bus.grant_bank, bus.cmd_err, bus.stall_cycles);
    end
    rst_n = 1'b1;
    act_hist.delete();
    tick();
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b want 1", bus.req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      cnt[3] = 0; drive_banks();
      tick();
      n_cmp++;
      if (bus.grant_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL dropped_grant: gv=%b want 0 (k %0d)", bus.grant_valid, k);
      end
    end
    auto_dec = 1'b1;
    clear_banks();
  endtask

  task automatic test_stall_sat();
    int g;
    auto_dec = 1'b0;
    clear_banks();
    cnt[4] = 31; code[4] = 3; drive_banks();
    run_req(3, 4, 300, g);
    auto_dec = 1'b1;
    clear_banks();
  endtask

  task automatic test_random(input int n);
    int g, cmd, bank;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < NB; b++) begin
        cnt[b]  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12)) : 0;
        code[b] = int'($urandom_range(0, 6));
        ras[b]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
      end
      drive_banks();
      cmd  = int'($urandom_range(0, 7));
      bank = int'($urandom_range(0, NB - 1));
      run_req(cmd, bank, -1, g);
    end
  endtask

  initial begin
    test_reset();
    test_act_basic();
    test_rd_wait();
    test_back_to_back();
    test_illegal();
    test_faw();
    test_reset_in_wait();
    test_stall_sat();
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
